// File: rtl/cache_pkg.sv
// Shared geometry, backing-store pattern and address-split helpers for the
// direct-mapped read-only cache.
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int INDEX_BITS  = 6;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_LINES   = 1 << INDEX_BITS;

  // Backing-store contents are the word-aligned address XOR this pattern.
  localparam logic [DATA_W-1:0] MEM_PATTERN = 32'hA5A5_A5A5;

  // Clears the byte-offset bits so every byte of a word maps to the same word.
  localparam logic [ADDR_W-1:0] OFFSET_MASK = 32'h0000_0003;

  // Line index: the bits just above the byte offset.
  function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

  // Tag: everything above the index.
  function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_BITS];
  endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// Combinational, read-only backing store model. Returns the word containing
// the given byte address. Kept as its own block so a real memory can replace it.
module cache_backing_mem
  import cache_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Word content is derived from the word-aligned address.
  always_comb begin
    data = (addr & ~OFFSET_MASK) ^ MEM_PATTERN;
  end

endmodule

// File: rtl/cache.sv
// Direct-mapped, read-only, one-word-per-line cache. Every rising edge looks
// up the presented byte address, registers hit/miss and the data word, and
// fills the line on a miss in the same edge.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic              hit_miss,
  output logic [DATA_W-1:0] out
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  logic [NUM_LINES-1:0]  valid_r;
  logic [TAG_BITS-1:0]   tag_ram_r  [NUM_LINES];
  logic [DATA_W-1:0]     data_ram_r [NUM_LINES];

  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s;
  logic [DATA_W-1:0]     mem_word_s;

  cache_backing_mem u_backing_mem (
    .addr (address),
    .data (mem_word_s)
  );

  // Split the address and decide hit/miss against the state before the edge.
  always_comb begin
    index_s = get_index(address);
    tag_s   = get_tag(address);
    hit_s   = 1'b0;
    if (valid_r[index_s] && (tag_ram_r[index_s] == tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Valid bits: cleared by reset, set for the indexed line on every miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (!hit_s) begin
      valid_r[index_s] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; a fill during reset is harmless because
  // the valid bit stays cleared until reset is released.
  always_ff @(posedge clk) begin
    if (!hit_s) begin
      tag_ram_r[index_s]  <= tag_s;
      data_ram_r[index_s] <= mem_word_s;
    end
  end

  // Registered lookup result: cached word on a hit, backing word on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_miss <= 1'b0;
      out      <= {DATA_W{1'b0}};
    end else if (hit_s) begin
      hit_miss <= 1'b1;
      out      <= data_ram_r[index_s];
    end else begin
      hit_miss <= 1'b0;
      out      <= mem_word_s;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, one of them advancing on every lookup edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (hit_s) begin
      if (hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
    end else begin
      if (miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for the direct-mapped cache. A reference model predicts
// hit/miss and data for every driven address and queues the expectation; the
// registered result is popped and compared one edge later. Scenario tasks also
// compare against fixed expected words. Define CACHE_STATS_EN to cover counters.
module tb_cache;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        hit_miss;
  logic [31:0] out;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  bit          model_valid[64];
  logic [23:0] model_tag[64];
  int          model_hits   = 0;
  int          model_misses = 0;

  cache dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .hit_miss (hit_miss),
    .out      (out)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    model_hits   = 0;
    model_misses = 0;
  endtask

  // Drive one address for one edge, queue the model prediction, check result.
  task automatic step(input logic [31:0] a);
    exp_t e;
    exp_t got;
    int   idx;
    @(negedge clk);
    address = a;
    idx     = int'(a[7:2]);
    e.addr  = a;
    e.data  = exp_word(a);
    e.hit   = model_valid[idx] && (model_tag[idx] == a[31:8]);
    if (e.hit) begin
      model_hits++;
    end else begin
      model_misses++;
      model_valid[idx] = 1'b1;
      model_tag[idx]   = a[31:8];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expectation queued for addr %h", a);
    end else begin
      got = sb.pop_front();
      if (hit_miss !== got.hit) begin
        errors++;
        $display("FAIL hit_miss addr=%h: got %b expected %b", got.addr, hit_miss, got.hit);
      end
      checks++;
      if (out !== got.data) begin
        errors++;
        $display("FAIL out addr=%h: got %h expected %h", got.addr, out, got.data);
      end
    end
  endtask

  // Hold an address n edges; also compare against fixed scenario values.
  task automatic hold(input logic [31:0] a, input int n, input logic first_hit,
                      input logic [31:0] word, input string name);
    for (int i = 0; i < n; i++) begin
      step(a);
      checks++;
      if (hit_miss !== ((i == 0) ? first_hit : 1'b1)) begin
        errors++;
        $display("FAIL %s edge%0d hit_miss: got %b expected %b", name, i + 1, hit_miss,
                 (i == 0) ? first_hit : 1'b1);
      end
      checks++;
      if (out !== word) begin
        errors++;
        $display("FAIL %s edge%0d out: got %h expected %h", name, i + 1, out, word);
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    address = 32'h0000_0014;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hit_miss !== 1'b0 || out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got hit_miss=%b out=%h expected 0/00000000", hit_miss, out);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_scenarios();
    hold(32'h0000_0014, 5, 1'b0, 32'hA5A5_A5B1, "s1_cold");
    hold(32'h0000_0014, 5, 1'b1, 32'hA5A5_A5B1, "s2_warm");
    hold(32'h0000_0214, 5, 1'b0, 32'hA5A5_A7B1, "s3_conflict");
    hold(32'h0000_0016, 5, 1'b0, 32'hA5A5_A5B1, "s4_evict_back");
    hold(32'h0000_0217, 5, 1'b0, 32'hA5A5_A7B1, "s5_offset");
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd21 || miss_count !== 32'd4) begin
      errors++;
      $display("FAIL s6_counters: got hits=%0d misses=%0d expected 21/4", hit_count, miss_count);
    end
`endif
  endtask

  // Reset pulse while 0x217 is held: outputs clear at once, next edge misses.
  task automatic test_mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (hit_miss !== 1'b0 || out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: got hit_miss=%b out=%h expected 0/00000000", hit_miss, out);
    end
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (hit_miss !== 1'b0 || out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_held: got hit_miss=%b out=%h expected 0/00000000", hit_miss, out);
    end
    rst_n = 1'b1;
    hold(32'h0000_0217, 3, 1'b0, 32'hA5A5_A7B1, "s5_after_reset");
  endtask

  task automatic test_index_bounds();
    hold(32'h0000_0000, 2, 1'b0, 32'hA5A5_A5A5, "idx0");
    hold(32'h0000_00FC, 2, 1'b0, 32'hA5A5_A559, "idx63");
    hold(32'h0000_0003, 1, 1'b1, 32'hA5A5_A5A5, "idx0_offset");
    hold(32'h0000_0100, 2, 1'b0, 32'hA5A5_A4A5, "idx0_tag1");
    hold(32'h0000_00FD, 1, 1'b1, 32'hA5A5_A559, "idx63_kept");
    hold(32'hFFFF_FFFF, 2, 1'b0, 32'h5A5A_5A59, "top_addr");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {22'(0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
           2'($urandom_range(0, 3))};
      if (i % 7 == 0) a[31:28] = 4'($urandom_range(0, 15));
      step(a);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'(model_hits) || miss_count !== 32'(model_misses)) begin
      errors++;
      $display("FAIL b2b_counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count,
               model_hits, model_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_mid_reset();
    test_index_bounds();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
